// File: rtl/usart_tx_arbiter_if.sv
// rtl/usart_tx_arbiter_if.sv - requester/transmitter signal bundle for the USART frame arbiter
interface usart_tx_arbiter_if;
  logic [3:0]  req;
  logic [95:0] req_d;
  logic [7:0]  req_adress;
  logic [23:0] req_mod_sel;
  logic [3:0]  ack;
  logic        busy;
  logic        tx_trig;
  logic [23:0] tx_d;
  logic [1:0]  tx_adress;
  logic [5:0]  tx_mod_sel;

  modport master (
    output req, req_d, req_adress, req_mod_sel,
    input  ack, busy, tx_trig, tx_d, tx_adress, tx_mod_sel
  );

  modport slave (
    input  req, req_d, req_adress, req_mod_sel,
    output ack, busy, tx_trig, tx_d, tx_adress, tx_mod_sel
  );
endinterface

// File: rtl/usart_tx_arbiter.sv
// rtl/usart_tx_arbiter.sv - shares one 5-byte USART frame transmitter among 4 requesters
// USART_TX_ARB_FIXED_PRI_EN selects fixed priority (0 highest) instead of round-robin.
module usart_tx_arbiter #(
  parameter int TRIG_CYCLES  = 2,
  parameter int FRAME_CYCLES = 30016
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  usart_tx_arbiter_if.slave   bus
);

  localparam logic [15:0] TRIG_LAST  = 16'(TRIG_CYCLES - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  ptr;
  logic [1:0]  win;

  logic [23:0] d_arr   [4];
  logic [1:0]  adr_arr [4];
  logic [5:0]  mod_arr [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      d_arr[i]   = bus.req_d[24*i +: 24];
      adr_arr[i] = bus.req_adress[2*i +: 2];
      mod_arr[i] = bus.req_mod_sel[6*i +: 6];
    end
  end

`ifdef USART_TX_ARB_FIXED_PRI_EN
  // Scan from the lowest priority down so requester 0 overwrites everyone.
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) win = 2'(i);
    end
  end
`else
  logic       found;
  logic [1:0] idx;

  // Search starts at ptr and wraps mod 4 through the 2-bit add.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state          <= ST_IDLE;
      cnt            <= 16'd0;
      ptr            <= 2'd0;
      bus.ack        <= 4'd0;
      bus.busy       <= 1'b0;
      bus.tx_trig    <= 1'b0;
      bus.tx_d       <= 24'd0;
      bus.tx_adress  <= 2'd0;
      bus.tx_mod_sel <= 6'd0;
    end else begin
      bus.ack <= 4'd0;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            bus.ack        <= 4'b0001 << win;
            bus.tx_d       <= d_arr[win];
            bus.tx_adress  <= adr_arr[win];
            bus.tx_mod_sel <= mod_arr[win];
            bus.tx_trig    <= 1'b1;
            bus.busy       <= 1'b1;
            cnt            <= 16'd0;
`ifndef USART_TX_ARB_FIXED_PRI_EN
            ptr            <= win + 2'd1;
`endif
            state          <= ST_TRIG;
          end
        end
        ST_TRIG: begin
          if (cnt == TRIG_LAST) begin
            bus.tx_trig <= 1'b0;
            cnt         <= 16'd0;
            state       <= ST_WAIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WAIT: begin
          // The transmitter has no done flag, so the frame is timed out blind.
          if (cnt == FRAME_LAST) begin
            cnt      <= 16'd0;
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// tb/tb_usart_tx_arbiter.sv - directed self-checking bench for usart_tx_arbiter
module tb_usart_tx_arbiter;

  localparam logic [23:0] D0 = 24'hA5B6C7, D1 = 24'h112233, D2 = 24'h445566, D3 = 24'h778899;
  localparam logic [1:0]  A0 = 2'd2, A1 = 2'd1, A2 = 2'd3, A3 = 2'd0;
  localparam logic [5:0]  M0 = 6'h15, M1 = 6'h2A, M2 = 6'h3F, M3 = 6'h01;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  usart_tx_arbiter_if bus ();

  usart_tx_arbiter #(
    .TRIG_CYCLES (2),
    .FRAME_CYCLES(20)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int bound, output int cyc);
    cyc = 0;
    do begin
      tick(1);
      cyc++;
    end while (bus.ack == 4'd0 && cyc < bound);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 60) begin
      tick(1);
      n++;
    end
    chk("busy_falls", 64'(bus.busy), 64'd0);
  endtask

  logic [23:0] dtab [4];
  int          rr_idx [5];
  int          alt_idx [4];
  int          c, n, ack_n, trig_n, busy_n;
  logic [3:0]  exp_busy_grant, exp_ptr_grant;
  logic [23:0] exp_busy_d;

  initial begin
    dtab = '{D0, D1, D2, D3};
`ifdef USART_TX_ARB_FIXED_PRI_EN
    rr_idx         = '{0, 0, 0, 0, 0};
    alt_idx        = '{1, 1, 1, 1};
    exp_busy_grant = 4'b0001;
    exp_busy_d     = D0;
    exp_ptr_grant  = 4'b0010;
`else
    rr_idx         = '{0, 1, 2, 3, 0};
    alt_idx        = '{3, 1, 3, 1};
    exp_busy_grant = 4'b0100;
    exp_busy_d     = D2;
    exp_ptr_grant  = 4'b0100;
`endif
    bus.req         = 4'hF;
    bus.req_d       = {D3, D2, D1, D0};
    bus.req_adress  = {A3, A2, A1, A0};
    bus.req_mod_sel = {M3, M2, M1, M0};

    // Reset held 3 cycles with every requester active.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("reset_outputs", 64'({bus.ack, bus.busy, bus.tx_trig, bus.tx_d, bus.tx_adress, bus.tx_mod_sel}), 64'd0);
    end
    sys_rst = 1'b0;
    chk("no_ack_on_release", 64'(bus.ack), 64'd0);
    tick(1);
    chk("first_grant_ack", 64'(bus.ack), 64'b0001);
    chk("first_grant_d", 64'(bus.tx_d), 64'(D0));
    bus.req = 4'd0;
    wait_idle();

    // Single request: ack width, payload, trig and busy lengths.
    bus.req = 4'b0001;
    tick(1);
    chk("single_ack", 64'(bus.ack), 64'b0001);
    chk("single_payload", 64'({bus.tx_d, bus.tx_adress, bus.tx_mod_sel}), 64'({24'hA5B6C7, 2'd2, 6'h15}));
    bus.req = 4'd0;
    ack_n = 0; trig_n = 0; busy_n = 0; n = 0;
    while (bus.busy && n < 60) begin
      if (bus.ack != 4'd0) ack_n++;
      if (bus.tx_trig) trig_n++;
      busy_n++;
      tick(1);
      n++;
    end
    chk("single_ack_cycles", 64'(ack_n), 64'd1);
    chk("single_trig_cycles", 64'(trig_n), 64'd2);
    chk("single_busy_cycles", 64'(busy_n), 64'd22);

    // Round-robin from a fresh pointer with all four requesting.
    sys_rst = 1'b1;
    tick(2);
    sys_rst = 1'b0;
    bus.req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_ack(40, c);
      chk("rr_ack", 64'(bus.ack), 64'(4'b0001 << rr_idx[g]));
      chk("rr_tx_d", 64'(bus.tx_d), 64'(dtab[rr_idx[g]]));
      chk("rr_spacing", 64'(c), (g == 0) ? 64'd1 : 64'd23);
    end
    bus.req = 4'd0;
    wait_idle();

    // Request arriving mid-frame waits for one IDLE cycle.
    bus.req = 4'b0001;
    wait_ack(40, c);
    chk("busy_req_first_ack", 64'(bus.ack), 64'b0001);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("busy_req_tx_stable", 64'({bus.tx_d, bus.tx_adress, bus.tx_mod_sel}), 64'({D0, A0, M0}));
    end
    bus.req = 4'b0101;
    n = 0;
    while (bus.busy && n < 60) begin
      tick(1);
      n++;
      chk("busy_req_tx_stable", 64'({bus.tx_d, bus.tx_adress, bus.tx_mod_sel}), 64'({D0, A0, M0}));
    end
    wait_ack(40, c);
    chk("busy_req_second_ack", 64'(bus.ack), 64'(exp_busy_grant));
    chk("busy_req_idle_gap", 64'(c), 64'd1);
    chk("busy_req_second_d", 64'(bus.tx_d), 64'(exp_busy_d));
    bus.req = 4'd0;
    wait_idle();

    // Reset at WAIT cnt=10 with requester 1 held.
    bus.req = 4'b0010;
    wait_ack(40, c);
    chk("midwait_first_ack", 64'(bus.ack), 64'b0010);
    tick(12);
    chk("midwait_in_wait", 64'({bus.busy, bus.tx_trig}), 64'b10);
    sys_rst = 1'b1;
    tick(1);
    chk("midwait_reset_state", 64'({bus.busy, bus.tx_trig}), 64'b00);
    sys_rst = 1'b0;
    tick(1);
    chk("midwait_regrant", 64'(bus.ack), 64'b0010);
    bus.req = 4'd0;
    wait_idle();
    bus.req = 4'b1110;
    wait_ack(40, c);
    chk("midwait_ptr_after", 64'(bus.ack), 64'(exp_ptr_grant));
    bus.req = 4'd0;
    wait_idle();

    // Requesters 1 and 3 held together.
    bus.req = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      wait_ack(40, c);
      chk("alt_ack", 64'(bus.ack), 64'(4'b0001 << alt_idx[g]));
      chk("alt_tx_d", 64'(bus.tx_d), 64'(dtab[alt_idx[g]]));
    end
    bus.req = 4'd0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usart_tx_arbiter.md
Name: usart_tx_arbiter

Overview:
- Shares one 5-byte USART frame transmitter among 4 requesters.
- The transmitter is edge-triggered on `trig` and samples `D` / `Adress` / `Mod_SEL` a few cycles after the rising edge. It has no busy or done output.
- This block arbitrates the requests, latches the winner's payload, and holds it stable. It pulses the transmitter trigger, then times out the frame before granting again.
- Sits between the measurement/command sources and the frame transmitter.

Parameters:
- TRIG_CYCLES, 2: cycles `tx_trig` is held high per frame; legal range 1..255.
- FRAME_CYCLES, 30016: hold-off after `tx_trig` falls, covering 5 bytes × 6000 clocks plus margin; legal range 1..65535.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- req  in  4  request per requester; held high until its `ack` bit is seen.
- req_d  in  96  24-bit payload per requester; requester i uses bits [24i+23:24i].
- req_adress  in  8  2-bit address per requester; requester i uses bits [2i+1:2i].
- req_mod_sel  in  24  6-bit mode select per requester; requester i uses bits [6i+5:6i].
- ack  out  4  one-hot, 1-cycle pulse: the payload of that requester has been latched.
- busy  out  1  high while a frame is being triggered or timed.
- tx_trig  out  1  to transmitter `trig`.
- tx_d  out  24  to transmitter `D`.
- tx_adress  out  2  to transmitter `Adress`.
- tx_mod_sel  out  6  to transmitter `Mod_SEL`.

Behaviour:
- Reset, synchronous and dominant over all other logic. Every output returns to 0: `ack`, `busy`, `tx_trig`, `tx_d`, `tx_adress`, `tx_mod_sel`. State goes to IDLE, `cnt` to 0, round-robin pointer `ptr` to 0.
- Reset mid-frame aborts timing immediately. The next `req` is granted with no leftover hold-off.
- Requesters must keep payload stable while their `req` is high and not yet acked. The block samples only at the grant edge.

FSM states:
- IDLE, `busy`=0:
  - If `req`≠0, pick winner k by round-robin. Search order is `ptr`, `ptr`+1, … mod 4; first set bit wins.
  - On that edge: `ack`<=onehot(k); `tx_*`<=payload k; `tx_trig`<=1; `cnt`<=0; `ptr`<=(k+1) mod 4; state<=TRIG.
  - If `req`=0, remain in IDLE.
- TRIG, `busy`=1:
  - `cnt` increments each cycle.
  - When `cnt`=TRIG_CYCLES-1: `tx_trig`<=0, `cnt`<=0, state<=WAIT.
  - `tx_trig` is therefore high for exactly TRIG_CYCLES cycles.
- WAIT, `busy`=1:
  - `cnt` increments each cycle.
  - When `cnt`=FRAME_CYCLES-1: `cnt`<=0, state<=IDLE.

Timing and signal rules:
- `ack` is high only in the cycle after the grant edge; 0 otherwise.
- `busy` is registered with state. It is high for TRIG_CYCLES+FRAME_CYCLES cycles per frame.
- `tx_d` / `tx_adress` / `tx_mod_sel` hold their value from the grant until the next grant. They do not change during TRIG or WAIT.
- Minimum grant-to-grant spacing is TRIG_CYCLES+FRAME_CYCLES+1 cycles, because at least one IDLE cycle sits between frames.
- Requests that arrive or change during TRIG/WAIT are ignored until IDLE. No queueing beyond the `req` levels.
- A requester that drops `req` before being acked is simply not served.
- A requester that keeps `req` high after its `ack` is treated as a new request.
- `cnt` is 16 bits wide; it never wraps under the legal parameter ranges.
- `ptr` update is mod 4: 3 wraps to 0.

Optional Feature:
- Macro: USART_TX_ARB_FIXED_PRI_EN.
- Defined: fixed priority; requester 0 highest, 3 lowest. `ptr` is not used and stays 0.
- Undefined: round-robin as described above.
- All other timing is identical in both modes.

Test Plan:
- Use TRIG_CYCLES=2 and FRAME_CYCLES=20 for all scenarios.
- Reset values: assert `sys_rst` for 3 cycles with `req`=4'hF. Required: all outputs 0 throughout, and no `ack` on the release cycle. The first grant goes to requester 0 on the first edge after release.
- Single request: `req`=4'b0001, `req_d`[23:0]=24'hA5B6C7, `req_adress`[1:0]=2, `req_mod_sel`[5:0]=6'h15. Required:
  - `ack`=4'b0001 for 1 cycle;
  - `tx_d`=24'hA5B6C7, `tx_adress`=2, `tx_mod_sel`=6'h15 in that same cycle;
  - `tx_trig` high 2 cycles;
  - `busy` high 22 cycles.
- Round-robin: `req`=4'hF held, each requester with a distinct payload. Required: `ack` order 0,1,2,3,0. Grants are 23 cycles apart, and each frame's `tx_d` matches the granted requester.
- Request during busy: `req`=4'b0001 and, 5 cycles later, `req`=4'b0101 held. Required: requester 2 is acked the edge after `busy` falls (1 IDLE cycle). `tx_*` stays stable during the first frame.
- Reset mid-WAIT: assert `sys_rst` at WAIT `cnt`=10 with `req`=4'b0010 held. Required:
  - the next cycle shows `busy`=0 and `tx_trig`=0;
  - after release, requester 1 is acked immediately;
  - `ptr` becomes 2.
- With USART_TX_ARB_FIXED_PRI_EN: `req`=4'b1010 held. Required: `ack`=4'b0010 on every grant and requester 3 is never served. Without the macro, the same stimulus alternates between requesters 1 and 3.
